// File: rtl/mul_pipe_pkg.sv
// Shared definitions for the multiplier pipeline and its downstream consumers.
// Holds latency/width defaults, the accumulator FSM states and the counter-width helper.
package mul_pipe_pkg;

    localparam int PROD_W_DEF      = 16;
    localparam int MUL_LATENCY_DEF = 3;
    localparam int LEN_DEF         = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Width of a counter that must reach len-1; never narrower than one bit.
    function automatic int cnt_width(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    localparam int CNT_W_DEF = cnt_width(LEN_DEF);

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that tracks issue validity through a fixed-latency pipeline.
// A synchronous flush empties every stage; the asynchronous reset does the same.
module valid_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    generate
        if (DEPTH == 1) begin : g_single
            always_comb stage_d = valid_i;
        end else begin : g_multi
            always_comb stage_d = {stage_q[DEPTH-2:0], valid_i};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else if (flush_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_o = stage_q[DEPTH-1];

endmodule

// File: rtl/product_accumulator.sv
// Sums each group of LEN valid multiplier products and presents the total on a valid/ready port.
// Build option: define ACC_SATURATE_EN for saturating accumulation with a per-group overflow flag.
module product_accumulator
    import mul_pipe_pkg::*;
#(
    parameter int PROD_W      = PROD_W_DEF,
    parameter int ACC_W       = 18,
    parameter int LEN         = LEN_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [PROD_W-1:0] product,
    input  logic              clear,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              sum_ovf,
    output logic              state_dbg
);

    localparam int CNT_W = cnt_width(LEN);

    // Output handshake: sum is transferred in any cycle where sum_valid && sum_ready
    // is high at the rising edge; sum/sum_ovf are held stable until then.
    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;

    logic             issue_fire;
    logic             dl_out;
    logic             pv;
    logic             last;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] prod_ext;

    assign issue_ready = !(state_q == HOLD && !sum_ready);
    assign issue_fire  = issue_valid && issue_ready;

    valid_delay_line #(
        .DEPTH (MUL_LATENCY)
    ) u_valid_delay_line (
        .clk     (clk),
        .reset   (reset),
        .flush_i (clear),
        .valid_i (issue_fire),
        .valid_o (dl_out)
    );

    // A clear in the same cycle as a returning product discards that product.
    assign pv       = dl_out && !clear;
    assign last     = pv && (cnt_q == CNT_W'(LEN - 1));
    assign prod_ext = {{(ACC_W - PROD_W){1'b0}}, product};

`ifdef ACC_SATURATE_EN
    logic [ACC_W:0] add_w;
    logic           grp_ovf;
    logic           ovf_q;
    logic           sum_ovf_q;

    assign add_w    = {1'b0, acc_q} + {1'b0, prod_ext};
    assign acc_next = add_w[ACC_W] ? {ACC_W{1'b1}} : add_w[ACC_W-1:0];
    assign grp_ovf  = ovf_q | add_w[ACC_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            sum_ovf_q <= 1'b0;
        end else if (clear) begin
            ovf_q     <= 1'b0;
        end else if (last) begin
            sum_ovf_q <= grp_ovf;
            ovf_q     <= 1'b0;
        end else if (pv) begin
            ovf_q     <= grp_ovf;
        end
    end

    assign sum_ovf = sum_ovf_q;
`else
    assign acc_next = acc_q + prod_ext;
    assign sum_ovf  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;

        if (state_q == HOLD && sum_ready) begin
            state_d = ACCUM;
        end

        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (last) begin
            // A completing group reloads the output even if the held sum leaves this cycle.
            sum_d   = acc_next;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
        end else if (pv) begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = (state_q == HOLD);
    assign state_dbg = (state_q == HOLD);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with a behavioural 3-stage multiplier feeding both instances.
// One instance uses LEN=4, the other LEN=8; each has its own expected-sum queue.
module tb_product_accumulator;

    localparam int PROD_W  = 16;
    localparam int ACC_W   = 18;
    localparam int W       = ACC_W + 1;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     = 1'b0;
    logic       clear     = 1'b0;
    logic       sum_ready = 1'b1;
    logic       iv4       = 1'b0;
    logic       iv8       = 1'b0;
    logic [7:0] op_a      = '0;
    logic [7:0] op_b      = '0;

    logic [PROD_W-1:0] p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clk) begin
        p1 <= op_a * op_b;
        p2 <= p1;
        p3 <= p2;
    end

    logic             ir4, sv4, ovf4, st4;
    logic [ACC_W-1:0] s4;
    logic             ir8, sv8, ovf8, st8;
    logic [ACC_W-1:0] s8;

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN(4), .MUL_LATENCY(3)) dut4 (
        .clk(clk), .reset(reset), .issue_valid(iv4), .issue_ready(ir4), .product(p3),
        .clear(clear), .sum(s4), .sum_valid(sv4), .sum_ready(sum_ready), .sum_ovf(ovf4),
        .state_dbg(st4)
    );

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN(8), .MUL_LATENCY(3)) dut8 (
        .clk(clk), .reset(reset), .issue_valid(iv8), .issue_ready(ir8), .product(p3),
        .clear(clear), .sum(s8), .sum_valid(sv8), .sum_ready(sum_ready), .sum_ovf(ovf8),
        .state_dbg(st8)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp4_q[$];
    logic [W-1:0] exp8_q[$];
    int grp_acc[2];
    int grp_n[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            grp_acc[i] = 0;
            grp_n[i]   = 0;
        end
    endtask

    task automatic model_accept(input int which, input int prod);
        int len;
        logic [W-1:0] e;
        len = (which == 1) ? 8 : 4;
        grp_acc[which] += prod;
        grp_n[which]++;
        if (grp_n[which] == len) begin
`ifdef ACC_SATURATE_EN
            if (grp_acc[which] > ACC_MAX) e = {1'b1, ACC_W'(ACC_MAX)};
            else                          e = {1'b0, ACC_W'(grp_acc[which])};
`else
            e = {1'b0, ACC_W'(grp_acc[which] % (ACC_MAX + 1))};
`endif
            if (which == 1) exp8_q.push_back(e);
            else            exp4_q.push_back(e);
            grp_acc[which] = 0;
            grp_n[which]   = 0;
        end
    endtask

    task automatic issue(input int which, input int a, input int b);
        logic ok;
        logic accepted;
        accepted = 1'b0;
        op_a = 8'(a);
        op_b = 8'(b);
        if (which == 1) iv8 = 1'b1;
        else            iv4 = 1'b1;
        for (int k = 0; k < 64 && !accepted; k++) begin
            @(negedge clk);
            ok = (which == 1) ? ir8 : ir4;
            @(posedge clk);
            #1;
            if (ok) begin
                model_accept(which, a * b);
                accepted = 1'b1;
            end
        end
        if (!accepted) fail_now("issue_timeout");
    endtask

    task automatic idle();
        iv4 = 1'b0;
        iv8 = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && (exp4_q.size() != 0 || exp8_q.size() != 0); k++) tick();
        check({tag, "_q4_empty"}, exp4_q.size(), 0);
        check({tag, "_q8_empty"}, exp8_q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset && sv4 && sum_ready) begin
            if (exp4_q.size() == 0) begin
                fail_now("unexpected_sum4");
            end else begin
                e = exp4_q.pop_front();
                check("sum4", 32'(s4), 32'(e[ACC_W-1:0]));
                check("ovf4", 32'(ovf4), 32'(e[ACC_W]));
            end
        end
        if (!reset && sv8 && sum_ready) begin
            if (exp8_q.size() == 0) begin
                fail_now("unexpected_sum8");
            end else begin
                e = exp8_q.pop_front();
                check("sum8", 32'(s8), 32'(e[ACC_W-1:0]));
                check("ovf8", 32'(ovf8), 32'(e[ACC_W]));
            end
        end
    end

    initial begin
        logic [ACC_W-1:0] held;
        model_reset();

        // Reset asserted mid-cycle
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_sum", 32'(s4), 0);
        check("rst_valid", 32'(sv4), 0);
        check("rst_ovf", 32'(ovf4), 0);
        check("rst_ready", 32'(ir4), 1);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("rst_rel_ready", 32'(ir4), 1);
        check("rst_rel_valid", 32'(sv4), 0);
        check("rst_ready8", 32'(ir8), 1);
        tick();

        // Basic group with latency check
        issue(0, 10, 5);
        issue(0, 3, 7);
        issue(0, 15, 15);
        issue(0, 25, 12);
        idle();
        check("lat_c1", 32'(sv4), 0);
        tick();
        check("lat_c2", 32'(sv4), 0);
        tick();
        check("lat_c3", 32'(sv4), 0);
        tick();
        check("lat_c4_valid", 32'(sv4), 1);
        check("lat_c4_sum", 32'(s4), 596);
        drain("basic");

        // Backpressure with products in flight
        sum_ready = 1'b0;
        issue(0, 1, 2);
        issue(0, 3, 4);
        issue(0, 5, 6);
        issue(0, 7, 8);
        fork
            begin
                issue(0, 9, 10);
                issue(0, 11, 12);
                issue(0, 13, 14);
                issue(0, 15, 16);
                idle();
            end
            begin
                for (int k = 0; k < 40 && !sv4; k++) tick();
                check("bp_valid_seen", 32'(sv4), 1);
                held = s4;
                check("bp_sum_a", 32'(held), 100);
                for (int c = 0; c < 6; c++) begin
                    check("bp_issue_ready", 32'(ir4), 0);
                    check("bp_sum_stable", 32'(s4), 32'(held));
                    check("bp_valid_held", 32'(sv4), 1);
                    tick();
                end
                sum_ready = 1'b1;
            end
        join
        drain("bp");

        // Overflow on the LEN=8 instance
        for (int i = 0; i < 8; i++) issue(1, 255, 255);
        idle();
        drain("ovf");

        // Clear with a product in flight, then gaps in issue
        issue(0, 9, 9);
        issue(0, 7, 3);
        idle();
        tick();
        clear = 1'b1;
        model_reset();
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(0, 8, 20);
            idle();
            if (i[0]) tick();
        end
        for (int k = 0; k < 10 && exp4_q.size() != 0; k++) begin
            if (sv4) check("clear_sum", 32'(s4), 640);
            tick();
        end
        drain("clear");

        // Reset while holding a sum with a product in flight
        sum_ready = 1'b0;
        issue(0, 20, 3);
        issue(0, 4, 4);
        issue(0, 6, 6);
        issue(0, 2, 9);
        issue(0, 30, 2);
        idle();
        for (int k = 0; k < 40 && !sv4; k++) tick();
        check("hold_before_reset", 32'(sv4), 1);
        #2 reset = 1'b1;
        exp4_q.delete();
        exp8_q.delete();
        model_reset();
        #1;
        check("hrst_sum", 32'(s4), 0);
        check("hrst_valid", 32'(sv4), 0);
        check("hrst_ready", 32'(ir4), 1);
        tick();
        check("hrst_hold_valid", 32'(sv4), 0);
        #2 reset = 1'b0;
        tick();
        sum_ready = 1'b1;
        issue(0, 2, 3);
        issue(0, 4, 5);
        issue(0, 6, 7);
        issue(0, 8, 9);
        idle();
        for (int k = 0; k < 10 && exp4_q.size() != 0; k++) begin
            if (sv4) check("post_reset_sum", 32'(s4), 140);
            tick();
        end
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the 3-stage pipelined multiplier. It tracks operand-issue validity through a delay line matched to the multiplier latency and sums each group of LEN consecutive valid products into one accumulated result. It presents that result on a valid/ready output port and throttles operand issue while a result is held, so no in-flight product is lost. It sits between the multiplier's `product` output and the filter/statistics logic that consumes group sums.

## Interface
- `PROD_W`, 16, product width (multiplier output width)
- `ACC_W`, 18, accumulator/sum width; must be ≥ PROD_W
- `LEN`, 8, products per group; legal range MUL_LATENCY+1 .. 256
- `MUL_LATENCY`, 3, multiplier clock latency from operand issue to product
- `clk` in 1 — rising-edge clock shared with the multiplier
- `reset` in 1 — asynchronous, active-high reset
- `issue_valid` in 1 — operands a/b are being presented to the multiplier this cycle
- `issue_ready` out 1 — operand issue allowed; an issue counts only when `issue_valid && issue_ready`
- `product` in PROD_W — multiplier output, unsigned
- `clear` in 1 — synchronous flush of the accumulation in progress
- `sum` out ACC_W — group sum, unsigned
- `sum_valid` out 1 — `sum` holds a completed group
- `sum_ready` in 1 — consumer accepts `sum` this cycle
- `sum_ovf` out 1 — the group in `sum` overflowed ACC_W (saturating build only)

## Operation
- Delay line: an accepted issue enters a MUL_LATENCY-deep valid shift register. Its output `pv` marks the cycle in which `product` belongs to that issue.
- Accumulator `acc` (ACC_W) and group counter `cnt` (0..LEN-1):
  - On `pv`: acc ← acc + zero-extended product; cnt increments.
  - On the LEN-th product: `sum` ← acc + product, `sum_valid` ← 1, acc ← 0, cnt ← 0.
- FSM, two states:
  - ACCUM: output register empty; goes to HOLD when a group completes.
  - HOLD: `sum_valid`=1; goes to ACCUM on `sum_valid && sum_ready`. If a group completes in the same cycle the held sum is taken, the new sum loads and the state stays HOLD.
- `issue_ready` = !(state==HOLD && !sum_ready), combinational.
  - At most MUL_LATENCY products are in flight when HOLD begins.
  - LEN > MUL_LATENCY guarantees they cannot complete another group while the output is held.
  - Those in-flight products accumulate into the next group; none are dropped.
- Issues with `issue_ready` low are ignored; upstream holds its operands.
- `clear`: zeroes acc and cnt and empties the delay line, discarding in-flight products. A held `sum` and `sum_valid` are unaffected. If `clear` coincides with `pv`, clear wins and the product is discarded.
- `reset` mid-operation: all state is discarded immediately, including a held sum.

## Timing
- Reset values: `sum`=0, `sum_valid`=0, `sum_ovf`=0, acc=0, cnt=0, delay line empty, state ACCUM, so `issue_ready`=1.
- Issue at cycle t → `pv` at cycle t+MUL_LATENCY → product added at the end of that cycle.
- Last issue of a group at cycle t → `sum_valid` high at cycle t+MUL_LATENCY+1 (4 cycles by default).
- `sum` and `sum_ovf` are stable while `sum_valid && !sum_ready`.
- Gaps in `issue_valid` are allowed; grouping counts valid products only.
- Back-to-back groups with `sum_ready` tied high: full throughput, one product per cycle.

## Configuration
- `ACC_SATURATE_EN` defined:
  - Any addition exceeding 2^ACC_W-1 clamps acc to 2^ACC_W-1 and sets a sticky per-group overflow flag.
  - The flag transfers to `sum_ovf` together with `sum`, then clears for the next group.
- `ACC_SATURATE_EN` undefined:
  - Additions wrap modulo 2^ACC_W.
  - `sum_ovf` is tied to 0.

## Structure
- Shared package `mul_pipe_pkg` holds:
  - the PROD_W and MUL_LATENCY defaults, shared with the multiplier;
  - the FSM state enum (ACCUM, HOLD);
  - the `clog2`-based counter width constant.
- One sub-module, `valid_delay_line`: parameterised depth, async active-high reset, synchronous flush input. It is reused wherever issue validity must track the multiplier.

## Test plan
- Reset: assert `reset` mid-cycle → `sum`=0, `sum_valid`=0, `sum_ovf`=0, `issue_ready`=1 immediately and through deassertion.
- LEN=4, consecutive issues of 10×5, 3×7, 15×15, 25×12 → `sum`=596, `sum_valid` rises 4 cycles after the last issue.
- Backpressure (LEN=4): hold `sum_ready`=0 for 6 cycles after a sum appears, with issues pending.
  - `issue_ready` stays low and `sum` stays stable.
  - The 3 in-flight products are kept; the next group sum is exact.
- Overflow (LEN=8, ACC_W=18): eight issues of 255×255.
  - With `ACC_SATURATE_EN`: `sum`=262143, `sum_ovf`=1.
  - Without it: `sum`=258056, `sum_ovf`=0.
- Clear (LEN=4): issue 2 products, pulse `clear` while one is in flight, then issue 4×(8×20) → `sum`=640.
- Reset during HOLD with a product in flight → held sum lost, then a fresh group sums correctly.
